// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / load, plus counted burst.
// Optional macro ROTATE_EN adds a rot port that feeds the shifted-out bit back in.
module univ_shift_reg #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             go,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] cnt,
   input  logic             sin_msb,
   input  logic             sin_lsb,
   input  logic [WIDTH-1:0] d,
`ifdef ROTATE_EN
   input  logic             rot,
`endif
   output logic [WIDTH-1:0] q,
   output logic             sout_lsb,
   output logic             sout_msb,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] DONE_S = 2'd2;

   localparam logic [1:0] M_HOLD  = 2'b00;
   localparam logic [1:0] M_RIGHT = 2'b01;
   localparam logic [1:0] M_LEFT  = 2'b10;
   localparam logic [1:0] M_LOAD  = 2'b11;

   logic [1:0]       state;
   logic [1:0]       op_r;
   logic [CNT_W-1:0] rem;
   logic             rot_r;

   logic             is_shift;
   logic             accept;
   logic             do_step;
   logic             do_run;
   logic [1:0]       cur_op;
   logic             cur_rot;
   logic             fill_r;
   logic             fill_l;
   logic [WIDTH-1:0] q_next;

   assign is_shift = (mode == M_RIGHT) || (mode == M_LEFT);
   assign accept   = (state == IDLE) && go && is_shift;
   assign do_step  = (state == IDLE) && !accept && (go || en);
   assign do_run   = (state == RUN);
   assign cur_op   = do_run ? op_r : mode;

`ifdef ROTATE_EN
   assign cur_rot = do_run ? rot_r : rot;
`else
   assign cur_rot = do_run ? rot_r : 1'b0;
`endif

   assign fill_r = cur_rot ? q[0] : sin_msb;
   assign fill_l = cur_rot ? q[WIDTH-1] : sin_lsb;

   always_comb begin
      q_next = q;
      case (cur_op)
         M_RIGHT: q_next = {fill_r, q[WIDTH-1:1]};
         M_LEFT:  q_next = {q[WIDTH-2:0], fill_l};
         M_LOAD:  q_next = d;
         default: q_next = q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= '0;
         state <= IDLE;
         op_r  <= M_HOLD;
         rem   <= '0;
         rot_r <= 1'b0;
      end else begin
         if (do_step || do_run)
            q <= q_next;
         case (state)
            IDLE: begin
               if (accept) begin
                  op_r  <= mode;
                  rem   <= cnt;
                  rot_r <= cur_rot;
                  state <= (cnt == '0) ? DONE_S : RUN;
               end
            end
            RUN: begin
               rem <= rem - CNT_W'(1);
               if (rem == CNT_W'(1))
                  state <= DONE_S;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sout_lsb = q[0];
   assign sout_msb = q[WIDTH-1];
   assign busy     = (state == RUN);
   assign done     = (state == DONE_S);

endmodule
